// File: rtl/dcmem_pkg.sv
// Shared definitions for the 128-bit line memory responder:
// FSM state encodings and default write/read latencies.
package dcmem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_WAIT = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RD_DATA = 3'd4
  } dcmem_state_e;

  localparam int unsigned WLAT_DEF = 4;
  localparam int unsigned RLAT_DEF = 4;

endpackage

// File: rtl/mem_1r1w_128.sv
// 128-bit wide line storage: one write port with per-byte enables,
// one read port with a registered output. Contents are never reset.
module mem_1r1w_128 #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_be,
  input  logic [127:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [127:0]  rd_data
);

  logic [127:0] mem [0:(1<<AW)-1];

  // Byte-granular write; disabled bytes keep their old contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 16; b++) begin
        if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Registered read: data appears the cycle after rd_en.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dc_mem_responder.sv
// Line-memory responder: one-deep write and read pending slots served by a
// small FSM with fixed write/read latencies and receiver backpressure on reads.
// Build option: DCMEM_RDLAT_EN -- when defined the read wait lasts RLAT
// cycles, otherwise the read wait is a single cycle.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a pending slot; write slot has priority
// ST_WR_WAIT | write latency countdown; masked RAM write on the last cycle
// ST_WR_RESP | one-cycle dcw_finish_wresp, write slot released
// ST_RD_WAIT | RAM read issued on entry; read latency countdown
// ST_RD_DATA | present line; pulse valid/finish once rqfull_1 is low
module dc_mem_responder
  import dcmem_pkg::*;
#(
  parameter int MWIDTH = 12,
  parameter int WLAT   = WLAT_DEF,
  parameter int RLAT   = RLAT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         dcw_start_rq,
  input  logic [31:0]  dcw_in_addr,
  input  logic [15:0]  dcw_in_mask,
  input  logic [127:0] dcw_in_data,
  output logic         dcw_finish_wresp,
  input  logic         dcr_start_rq,
  input  logic [31:0]  dcr_rin_addr,
  input  logic         rqfull_1,
  output logic [127:0] rdat_m_data,
  output logic         rdat_m_valid,
  output logic         finish_mrd,
  output logic         req_drop_err
);

  // Countdown loads; never zero so every response takes at least one wait cycle.
  localparam logic [3:0] WR_LOAD = (WLAT > 1) ? 4'(WLAT - 1) : 4'd1;
  localparam logic [3:0] RD_LOAD = (RLAT > 0) ? 4'(RLAT) : 4'd1;

  dcmem_state_e state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;

  logic              wr_full_q;
  logic [MWIDTH-1:0] wr_addr_q;
  logic [15:0]       wr_mask_q;
  logic [127:0]      wr_data_q;
  logic              rd_full_q;
  logic [MWIDTH-1:0] rd_addr_q;
  logic              drop_err_q;
  logic [127:0]      rdat_q;

  logic         wr_free, rd_free;
  logic         wr_accept, rd_accept;
  logic         mem_we, mem_re, cap_rdat;
  logic [127:0] mem_rd_data;

  // Only the line index participates; byte offset and upper bits wrap away.
  logic addr_unused;
  assign addr_unused = ^{dcw_in_addr[31:MWIDTH+4], dcw_in_addr[3:0],
                         dcr_rin_addr[31:MWIDTH+4], dcr_rin_addr[3:0]};

  // A slot accepts when empty or when it is being released this very cycle.
  assign wr_accept = dcw_start_rq & (~wr_full_q | wr_free);
  assign rd_accept = dcr_start_rq & (~rd_full_q | rd_free);

  // State and latency counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, RAM strobes and completion pulses.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    wr_free          = 1'b0;
    rd_free          = 1'b0;
    mem_we           = 1'b0;
    mem_re           = 1'b0;
    cap_rdat         = 1'b0;
    dcw_finish_wresp = 1'b0;
    rdat_m_valid     = 1'b0;
    finish_mrd       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_full_q) begin
          state_d = ST_WR_WAIT;
          cnt_d   = WR_LOAD;
        end else if (rd_full_q) begin
          state_d = ST_RD_WAIT;
          cnt_d   = RD_LOAD;
          mem_re  = 1'b1;
        end
      end
      ST_WR_WAIT: begin
        if (cnt_q <= 4'd1) begin
          mem_we  = 1'b1;
          state_d = ST_WR_RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_WR_RESP: begin
        dcw_finish_wresp = 1'b1;
        wr_free          = 1'b1;
        state_d          = ST_IDLE;
      end
      ST_RD_WAIT: begin
`ifdef DCMEM_RDLAT_EN
        if (cnt_q <= 4'd1) begin
          cap_rdat = 1'b1;
          state_d  = ST_RD_DATA;
          cnt_d    = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
`else
        cap_rdat = 1'b1;
        state_d  = ST_RD_DATA;
        cnt_d    = 4'd0;
`endif
      end
      ST_RD_DATA: begin
        if (!rqfull_1) begin
          rdat_m_valid = 1'b1;
          finish_mrd   = 1'b1;
          rd_free      = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write pending slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_full_q <= 1'b0;
      wr_addr_q <= '0;
      wr_mask_q <= '0;
      wr_data_q <= '0;
    end else if (wr_accept) begin
      wr_full_q <= 1'b1;
      wr_addr_q <= dcw_in_addr[MWIDTH+3:4];
      wr_mask_q <= dcw_in_mask;
      wr_data_q <= dcw_in_data;
    end else if (wr_free) begin
      wr_full_q <= 1'b0;
    end
  end

  // Read pending slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_full_q <= 1'b0;
      rd_addr_q <= '0;
    end else if (rd_accept) begin
      rd_full_q <= 1'b1;
      rd_addr_q <= dcr_rin_addr[MWIDTH+3:4];
    end else if (rd_free) begin
      rd_full_q <= 1'b0;
    end
  end

  // Sticky flag for requests that found their slot occupied.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_err_q <= 1'b0;
    end else if ((dcw_start_rq & ~wr_accept) | (dcr_start_rq & ~rd_accept)) begin
      drop_err_q <= 1'b1;
    end
  end

  // Returned line is captured on entry to RD_DATA and held until the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdat_q <= '0;
    end else if (cap_rdat) begin
      rdat_q <= mem_rd_data;
    end
  end

  assign rdat_m_data  = rdat_q;
  assign req_drop_err = drop_err_q;

  // Mask bit set means keep the byte, so the byte enable is its inverse.
  // Reset blocks a write landing on the same edge so an abandoned write has no effect.
  mem_1r1w_128 #(
    .AW(MWIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_we & ~rst),
    .wr_addr (wr_addr_q),
    .wr_be   (~wr_mask_q),
    .wr_data (wr_data_q),
    .rd_en   (mem_re),
    .rd_addr (rd_addr_q),
    .rd_data (mem_rd_data)
  );

endmodule

// File: tb/tb_dc_mem_responder.sv
// Self-checking bench for dc_mem_responder: directed scenarios plus randomized
// write/read traffic compared against a line-array reference model.
module tb_dc_mem_responder;

  localparam int MWIDTH = 12;
  localparam int WLAT   = 4;
  localparam int RLAT   = 4;

  // Latencies counted in cycles from the request cycle to the response cycle:
  // one idle cycle to notice the slot, the wait phase, then the response cycle.
  localparam int WR_LAT = 2 + ((WLAT > 1) ? WLAT - 1 : 1);
`ifdef DCMEM_RDLAT_EN
  localparam int RD_LAT = 2 + RLAT;
`else
  localparam int RD_LAT = 3;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         dcw_start_rq;
  logic [31:0]  dcw_in_addr;
  logic [15:0]  dcw_in_mask;
  logic [127:0] dcw_in_data;
  logic         dcw_finish_wresp;
  logic         dcr_start_rq;
  logic [31:0]  dcr_rin_addr;
  logic         rqfull_1;
  logic [127:0] rdat_m_data;
  logic         rdat_m_valid;
  logic         finish_mrd;
  logic         req_drop_err;

  int n_chk = 0;
  int n_err = 0;

  logic [127:0] ref_mem [int];

  always #5 clk = ~clk;

  dc_mem_responder #(
    .MWIDTH(MWIDTH),
    .WLAT  (WLAT),
    .RLAT  (RLAT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .dcw_start_rq     (dcw_start_rq),
    .dcw_in_addr      (dcw_in_addr),
    .dcw_in_mask      (dcw_in_mask),
    .dcw_in_data      (dcw_in_data),
    .dcw_finish_wresp (dcw_finish_wresp),
    .dcr_start_rq     (dcr_start_rq),
    .dcr_rin_addr     (dcr_rin_addr),
    .rqfull_1         (rqfull_1),
    .rdat_m_data      (rdat_m_data),
    .rdat_m_valid     (rdat_m_valid),
    .finish_mrd       (finish_mrd),
    .req_drop_err     (req_drop_err)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic int line_idx(input logic [31:0] a);
    return int'((a >> 4) & ((32'd1 << MWIDTH) - 32'd1));
  endfunction

  function automatic logic [127:0] ref_line(input logic [31:0] a);
    int i;
    i = line_idx(a);
    return ref_mem.exists(i) ? ref_mem[i] : '0;
  endfunction

  function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] data,
                                         input logic [15:0] mask);
    logic [127:0] r;
    r = old;
    for (int b = 0; b < 16; b++) if (!mask[b]) r[b*8 +: 8] = data[b*8 +: 8];
    return r;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [15:0] m, input logic [127:0] d);
    ref_mem[line_idx(a)] = merge(ref_line(a), d, m);
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Single write; checks response latency and that the pulse is one cycle wide.
  task automatic do_write(input logic [31:0] a, input logic [15:0] m, input logic [127:0] d,
                          input string tag);
    int seen_at;
    int pulses;
    seen_at = -1;
    pulses  = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      dcw_start_rq = (n == 0);
      if (n == 0) begin
        dcw_in_addr = a;
        dcw_in_mask = m;
        dcw_in_data = d;
      end else begin
        dcw_in_data = rand_line();
      end
      #1;
      if (dcw_finish_wresp) begin
        pulses++;
        if (seen_at < 0) seen_at = n;
      end
      if (seen_at >= 0 && n >= seen_at + 2) break;
    end
    chk({tag, "_wlat"}, seen_at, WR_LAT);
    chk({tag, "_wpulses"}, pulses, 1);
    ref_write(a, m, d);
  endtask

  // Single read with rqfull_1 held high for 'hold' cycles of the data phase.
  task automatic do_read(input logic [31:0] a, input int hold, input string tag);
    int seen_at;
    logic pair_ok;
    logic [127:0] exp_line, first_data, got;
    exp_line   = ref_line(a);
    seen_at    = -1;
    pair_ok    = 1'b1;
    first_data = '0;
    got        = '0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      dcr_start_rq = (n == 0);
      dcr_rin_addr = (n == 0) ? a : $urandom;
      rqfull_1     = (n < RD_LAT + hold);
      #1;
      if (rdat_m_valid !== finish_mrd) pair_ok = 1'b0;
      if (n == RD_LAT) first_data = rdat_m_data;
      if (rdat_m_valid) begin
        seen_at = n;
        got     = rdat_m_data;
        break;
      end
    end
    @(negedge clk);
    dcr_start_rq = 1'b0;
    rqfull_1     = 1'b0;
    #1;
    chk({tag, "_rlat"}, seen_at, RD_LAT + hold);
    chk({tag, "_rdata"}, got, exp_line);
    chk({tag, "_pair"}, pair_ok, 1);
    chk({tag, "_single"}, rdat_m_valid, 0);
    if (hold > 0) chk({tag, "_held"}, first_data, exp_line);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  a, b;
    logic [15:0]  m;
    logic [127:0] d, d2, got;
    int w_at, r_at, pulses, valids;
    logic [31:0] pool [$];

    rst          = 1'b1;
    dcw_start_rq = 1'b0;
    dcw_in_addr  = '0;
    dcw_in_mask  = '0;
    dcw_in_data  = '0;
    dcr_start_rq = 1'b0;
    dcr_rin_addr = '0;
    rqfull_1     = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_wresp", dcw_finish_wresp, 0);
    chk("rst_valid", rdat_m_valid, 0);
    chk("rst_finish", finish_mrd, 0);
    chk("rst_drop", req_drop_err, 0);
    chk("rst_rdata", rdat_m_data, 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic write then read of the same line.
    do_write(32'h0000_0040, 16'h0000, {16{8'hA5}}, "w40");
    do_read(32'h0000_0040, 0, "r40");

    // Masked write keeps all bytes except byte 0.
    do_write(32'h0000_0200, 16'h0000, '0, "w200z");
    do_write(32'h0000_0200, 16'hFFFE, {16{8'h11}}, "w200m");
    do_read(32'h0000_0200, 0, "r200");

    // Simultaneous write and read to one line: write completes first, read sees new data.
    d = rand_line();
    do_write(32'h0000_0100, 16'h0000, rand_line(), "w100");
    w_at = -1;
    r_at = -1;
    got  = '0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      dcw_start_rq = (n == 0);
      dcr_start_rq = (n == 0);
      dcw_in_addr  = 32'h0000_0100;
      dcw_in_mask  = 16'h0000;
      dcw_in_data  = d;
      dcr_rin_addr = 32'h0000_0100;
      rqfull_1     = 1'b0;
      #1;
      if (dcw_finish_wresp && w_at < 0) w_at = n;
      if (rdat_m_valid) begin
        r_at = n;
        got  = rdat_m_data;
        break;
      end
    end
    dcw_start_rq = 1'b0;
    dcr_start_rq = 1'b0;
    ref_write(32'h0000_0100, 16'h0000, d);
    chk("sim_wlat", w_at, WR_LAT);
    chk("sim_rlat", r_at, WR_LAT + RD_LAT);
    chk("sim_rdata", got, ref_line(32'h0000_0100));

    // Backpressure for 10 cycles during the data phase.
    do_read(32'h0000_0040, 10, "hold10");

    // Upper address bits and byte offset do not affect the line selected.
    do_write(32'hABC0_0357, 16'h0000, rand_line(), "wwrap");
    do_read(32'h0000_0350, 0, "rwrap");

    // A second read while the read slot is occupied is dropped.
    valids = 0;
    got    = '0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      dcr_start_rq = (n == 0) || (n == 1);
      dcr_rin_addr = (n == 0) ? 32'h0000_0040 : 32'h0000_0200;
      rqfull_1     = 1'b0;
      #1;
      if (rdat_m_valid) begin
        valids++;
        got = rdat_m_data;
      end
    end
    chk("drop_flag", req_drop_err, 1);
    chk("drop_valids", valids, 1);
    chk("drop_data", got, ref_line(32'h0000_0040));
    apply_reset();
    #1;
    chk("drop_clr", req_drop_err, 0);
    chk("drop_rdat_clr", rdat_m_data, 0);

    // A write request arriving in the response cycle of the previous write is accepted.
    a  = 32'h0000_0580;
    b  = 32'h0000_0590;
    d  = rand_line();
    d2 = rand_line();
    w_at   = -1;
    r_at   = -1;
    pulses = 0;
    for (int n = 0; n < 3 * WR_LAT; n++) begin
      @(negedge clk);
      dcw_start_rq = (n == 0) || (n == WR_LAT);
      dcw_in_addr  = (n == 0) ? a : b;
      dcw_in_mask  = 16'h0000;
      dcw_in_data  = (n == 0) ? d : d2;
      #1;
      if (dcw_finish_wresp) begin
        pulses++;
        if (w_at < 0) w_at = n;
        else r_at = n;
      end
    end
    dcw_start_rq = 1'b0;
    ref_write(a, 16'h0000, d);
    ref_write(b, 16'h0000, d2);
    chk("b2b_pulses", pulses, 2);
    chk("b2b_first", w_at, WR_LAT);
    chk("b2b_second", r_at, 2 * WR_LAT);
    chk("b2b_nodrop", req_drop_err, 0);
    do_read(b, 0, "rb2b");

    // Reset during the write wait abandons the write with no response.
    pulses = 0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      dcw_start_rq = (n == 0);
      dcw_in_addr  = 32'h0000_0040;
      dcw_in_mask  = 16'h0000;
      dcw_in_data  = rand_line();
      rst          = (n == 2);
      #1;
      if (dcw_finish_wresp) pulses++;
    end
    dcw_start_rq = 1'b0;
    chk("rstw_nowresp", pulses, 0);
    chk("rstw_drop", req_drop_err, 0);
    do_read(32'h0000_0040, 0, "rstw_read");

    // Randomized traffic over a small set of lines.
    for (int it = 0; it < 24; it++) begin
      if (pool.size() == 0 || $urandom_range(0, 1) == 1) begin
        a = ($urandom & 32'hFFFF_000F) | (32'($urandom_range(0, 15)) << 4) | 32'h0000_0800;
        m = ref_mem.exists(line_idx(a)) ? 16'($urandom) : 16'h0000;
        do_write(a, m, rand_line(), "rnd_w");
        pool.push_back(a);
      end else begin
        b = pool[$urandom_range(0, pool.size() - 1)];
        a = (b & 32'h0000_FFF0) | ($urandom & 32'hFFFF_000F);
        do_read(a, $urandom_range(0, 3), "rnd_r");
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
